// File: rtl/cap_comp_arbiter_if.sv
// Request channel into the capability compressor arbiter: valid/ready handshake
// carrying a 129-bit capability (bit 128 = tag) and a compress/pass-through select.
interface cap_comp_arbiter_if;
  logic         valid;
  logic         ready;
  logic [128:0] cap;
  logic         comp;

  modport master (output valid, output cap, output comp, input ready);
  modport slave  (input valid, input cap, input comp, output ready);
endinterface

// File: rtl/cap_comp_arbiter.sv
// Round-robin two-port arbiter in front of the shared capability compressor,
// with a single-entry registered output stage and a saturating lossy counter.
//
// state    | meaning
// ST_EMPTY | no result held, out_valid=0
// ST_FULL  | result held in out_*, out_valid=1
module cap_comp_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cap_comp_arbiter_if.slave    req0,
  cap_comp_arbiter_if.slave    req1,
  output logic [128:0]         o_comp_cap_in,
  output logic                 o_comp_enable,
  input  logic [128:0]         i_comp_cap_out,
  input  logic [21:0]          i_comp_mantissa,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [128:0]         o_out_cap,
  output logic [21:0]          o_out_mantissa,
  output logic                 o_out_src,
  output logic                 o_out_lossy,
  input  logic                 i_clear_count,
  output logic [CNT_W-1:0]     o_lossy_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_rr;
  logic         w_slot_free;
  logic         w_gnt_vld;
  logic         w_gnt_idx;
  logic [128:0] w_gnt_cap;
  logic         w_gnt_comp;
  logic         w_accept;
  logic         w_lossy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // The slot is reusable in the same cycle the consumer drains it, so
  // backpressure is the only thing that blocks a grant.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_free = (r_state == ST_EMPTY) || i_out_ready;
    w_gnt_vld   = w_slot_free && (req0.valid || req1.valid);
    w_gnt_idx   = (req0.valid && req1.valid) ? r_rr : req1.valid;
    w_gnt_cap   = w_gnt_idx ? req1.cap  : req0.cap;
    w_gnt_comp  = w_gnt_idx ? req1.comp : req0.comp;
    w_accept    = w_gnt_vld;
    w_lossy     = w_gnt_comp && (w_gnt_cap[9:0] != 10'd0);
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (i_out_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  assign req0.ready    = w_gnt_vld && !w_gnt_idx;
  assign req1.ready    = w_gnt_vld &&  w_gnt_idx;
  assign o_comp_cap_in = w_gnt_vld ? w_gnt_cap : 129'd0;
  assign o_comp_enable = w_gnt_vld && w_gnt_comp;
  assign o_out_valid   = (r_state == ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr           <= 1'b0;
      o_out_cap      <= '0;
      o_out_mantissa <= '0;
      o_out_src      <= 1'b0;
      o_out_lossy    <= 1'b0;
    end else if (w_accept) begin
      r_rr           <= !w_gnt_idx;
      o_out_cap      <= i_comp_cap_out;
      o_out_mantissa <= i_comp_mantissa;
      o_out_src      <= w_gnt_idx;
      o_out_lossy    <= w_lossy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_lossy_count <= '0;
    else if (i_clear_count)
      o_lossy_count <= '0;
    else if (w_accept && w_lossy && !(&o_lossy_count))
      o_lossy_count <= o_lossy_count + CNT_W'(1);
  end

endmodule

// File: doc/cap_comp_arbiter.md
# cap_comp_arbiter

Two-port arbiter and sequencer for the 129-bit capability compressor. It accepts capability compression requests from two requesters (e.g. store path and CSR/writeback path) over valid/ready handshakes and grants one per cycle, round-robin. It drives the shared combinational compressor and registers its result into a single-entry output stage with valid/ready. It also counts lossy compressions, where nonzero low mantissa bits are discarded.

## Interface
- CNT_W, 16, width of the saturating lossy-compression counter
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_cap  input  129  capability; bit 128 is the tag
- req0_comp  input  1  1 = compress, 0 = pass through
- req1_valid, req1_ready, req1_cap, req1_comp: same as requester 0
- comp_cap_in  output  129  capability driven to the compressor
- comp_enable  output  1  compressor enable_comp
- comp_cap_out  input  129  compressor result (combinational)
- comp_mantissa  input  22  compressor truncated mantissa (cap bits [31:10])
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result
- out_cap  output  129  registered compressor result
- out_mantissa  output  22  registered truncated mantissa
- out_src  output  1  requester index of held result
- out_lossy  output  1  held result dropped nonzero bits
- clear_count  input  1  synchronous clear of lossy_count
- lossy_count  output  CNT_W  saturating count of lossy compressions

## Operation
- Output stage FSM:
  - EMPTY (out_valid=0) to FULL on accept.
  - FULL with out_ready=1 and an accept stays FULL, loading the new result.
  - FULL with out_ready=1 and no accept goes to EMPTY.
  - FULL with out_ready=0 holds all out_* stable.
- slot_free = !out_valid || out_ready (combinational).
- Grant, combinational:
  - Only one requester valid: that requester.
  - Both valid: requester indexed by rr (reset 0).
  - Neither valid, or !slot_free: no grant.
- reqN_ready = slot_free && grant==N. Ready may depend on valid; valid must not depend on ready.
- Accept = granted reqN_valid && reqN_ready.
- rr <= 1 - granted index on every accept.
- Compressor inputs:
  - Grant present: comp_cap_in = granted cap; comp_enable = granted comp.
  - No grant: comp_cap_in = 0; comp_enable = 0.
- On accept, register:
  - out_cap <= comp_cap_out
  - out_mantissa <= comp_mantissa
  - out_src <= grant
  - out_lossy <= comp && (cap[9:0] != 0)
- Tag bit passes through unmodified by this block.
- lossy_count:
  - +1 on accept with lossy=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - clear_count wins over a same-cycle increment (result 0).

## Timing
- Reset values: out_valid=0, out_cap=0, out_mantissa=0, out_src=0, out_lossy=0, lossy_count=0, rr=0. reqN_ready, comp_enable and comp_cap_in are combinationally 0 while nothing is valid.
- Reset asserted mid-operation drops the held result immediately; no partial output.
- Latency: accept in cycle N gives out_valid=1 with the result in cycle N+1.
- Throughput: one result per cycle while out_ready=1.
- Backpressure: out_ready=0 while FULL forces both reqN_ready=0 and keeps out_* stable.
- Starvation bound: a continuously valid requester is granted within 2 accepts.

## Test plan
- Reset, then req0_valid=1, comp=1, cap[31:0]=0xFFFFFFFF, out_ready=1:
  - req0_ready=1 in cycle 0.
  - Cycle 1: out_valid=1, out_cap[31:0]=0xFFFFFC00, out_mantissa=0x3FFFFF, out_src=0, out_lossy=1, lossy_count=1.
- Both requesters valid continuously, out_ready=1:
  - Grants alternate 0,1,0,1 starting with 0.
  - out_src sequence 0,1,0,1 on consecutive cycles.
- out_ready=0 with result held, both requests valid for 3 cycles:
  - req0_ready=req1_ready=0; out_* unchanged.
  - out_ready=1 in the next cycle: accept occurs that same cycle (slot_free).
- comp=0, cap[9:0]=0x3FF:
  - out_cap equals comp_cap_out (pass-through), out_lossy=0, lossy_count unchanged.
- CNT_W=2, five lossy accepts:
  - lossy_count goes 1,2,3,3,3.
  - clear_count together with a lossy accept gives 0.
- rst_n low while out_valid=1:
  - out_valid=0 asynchronously, before the next clock edge.
  - After release, the first grant goes to req0 when both requesters are valid.
